// File: rtl/combo_lock_pkg.sv
// combo_lock_pkg: state encoding and display codes shared by the combination lock
package combo_lock_pkg;
    typedef enum logic [1:0] {ENTRY, PASS, FAIL, LOCKOUT} state_t;
    localparam logic [3:0] P     = 4'd10;
    localparam logic [3:0] A     = 4'd11;
    localparam logic [3:0] F     = 4'd12;
    localparam logic [3:0] L     = 4'd13;
    localparam logic [3:0] DASH  = 4'd14;
    localparam logic [3:0] BLANK = 4'd15;
endpackage

// File: rtl/combo_lock_ctrl_debounce.sv
// key_debounce: one-cycle press_pulse after DEBOUNCE_CYC consecutive low samples of key_n (CLOCK_50, reset in)
module key_debounce #(
    parameter int DEBOUNCE_CYC = 500000
) (
    input  logic CLOCK_50,
    input  logic reset,
    input  logic key_n,
    output logic press_pulse
);
    localparam int W = $clog2(DEBOUNCE_CYC + 1);
    logic [W-1:0] cnt;
    // Counter saturates at DEBOUNCE_CYC, so the DEBOUNCE_CYC-1 crossing happens once per press.
    always_ff @(posedge CLOCK_50) begin
        if (reset) begin
            cnt         <= '0;
            press_pulse <= 1'b0;
        end else begin
            cnt         <= key_n ? '0 : (cnt == W'(DEBOUNCE_CYC)) ? cnt : cnt + 1'b1;
            press_pulse <= !key_n && cnt == W'(DEBOUNCE_CYC - 1);
        end
    end
endmodule

// File: rtl/combo_lock_ctrl.sv
// combo_lock_ctrl: decimal code entry on key_n, compare with secret, PASS/FAIL scroll, timed lockout; drives disp codes, unlocked, locked_out, tries_left
module combo_lock_ctrl
    import combo_lock_pkg::*;
#(
    parameter int DIGITS       = 3,
    parameter int SECRET_W     = 10,
    parameter int NUM_DISP     = 6,
    parameter int DEBOUNCE_CYC = 500000,
    parameter int SCROLL_CYC   = 1000000,
    parameter int BLINK_CYC    = 12500000,
    parameter int MAX_TRIES    = 3,
    parameter int LOCKOUT_CYC  = 250000000
) (
    input  logic                           CLOCK_50,
    input  logic                           reset,
    input  logic [SECRET_W-1:0]            secret,
    input  logic [3:0]                     key_n,
    output logic [4*NUM_DISP-1:0]          disp,
    output logic                           unlocked,
    output logic                           locked_out,
    output logic [$clog2(MAX_TRIES+1)-1:0] tries_left
);
    localparam int TW  = $clog2(MAX_TRIES + 1);
    localparam int CW  = DIGITS > 1 ? $clog2(DIGITS) : 1;
    localparam int DW  = 4 * NUM_DISP;
    localparam int BLW = $clog2(BLINK_CYC + 1);
    localparam int SCW = $clog2(SCROLL_CYC + 1);
    localparam int LKW = $clog2(LOCKOUT_CYC + 1);
    localparam logic [DW-1:0] PASS_MSG = ({NUM_DISP{BLANK}} << 16) | DW'({P, A, 4'd5, 4'd5});
    localparam logic [DW-1:0] FAIL_MSG = ({NUM_DISP{BLANK}} << 16) | DW'({F, A, 4'd1, L});

    logic [3:0]          press;
    state_t              state, state_nx;
    logic [3:0]          digit [DIGITS];
    logic [3:0]          digit_nx [DIGITS];
    logic [CW-1:0]       cursor, cursor_nx;
    logic [TW-1:0]       fail_cnt, fail_nx;
    logic [DW-1:0]       frame, frame_nx;
    logic [SCW-1:0]      scroll_cnt, scroll_nx;
    logic [LKW-1:0]      lock_cnt, lock_nx;
    logic [BLW-1:0]      blink_cnt;
    logic                blink_off;
    logic                blink_wrap;
    logic [SECRET_W-1:0] value;

    for (genvar g = 0; g < 4; g++) begin : g_key
        key_debounce #(.DEBOUNCE_CYC(DEBOUNCE_CYC)) u_deb (
            .CLOCK_50   (CLOCK_50),
            .reset      (reset),
            .key_n      (key_n[g]),
            .press_pulse(press[g])
        );
    end

    assign blink_wrap = blink_cnt == BLW'(BLINK_CYC - 1);

    always_ff @(posedge CLOCK_50) begin
        if (reset) begin
            state      <= ENTRY;
            digit      <= '{default: '0};
            cursor     <= '0;
            fail_cnt   <= '0;
            frame      <= {NUM_DISP{BLANK}};
            scroll_cnt <= '0;
            lock_cnt   <= '0;
            blink_cnt  <= '0;
            blink_off  <= 1'b0;
        end else begin
            state      <= state_nx;
            digit      <= digit_nx;
            cursor     <= cursor_nx;
            fail_cnt   <= fail_nx;
            frame      <= frame_nx;
            scroll_cnt <= scroll_nx;
            lock_cnt   <= lock_nx;
            blink_cnt  <= blink_wrap ? '0 : blink_cnt + 1'b1;
            blink_off  <= blink_off ^ blink_wrap;
        end
    end

    // Timers not owned by the current state fall back to zero, so every entry starts a fresh count.
    always_comb begin
        state_nx  = state;
        digit_nx  = digit;
        cursor_nx = cursor;
        fail_nx   = fail_cnt;
        frame_nx  = frame;
        scroll_nx = '0;
        lock_nx   = '0;
        value     = '0;
        for (int i = DIGITS - 1; i >= 0; i--) value = value * SECRET_W'(10) + SECRET_W'(digit[i]);
        case (state)
            ENTRY: begin
                if (press[3]) begin
                    if (value == secret) begin
                        state_nx = PASS;
                        fail_nx  = '0;
                        frame_nx = PASS_MSG;
                    end else if (int'(fail_cnt) + 1 < MAX_TRIES) begin
                        state_nx = FAIL;
                        fail_nx  = fail_cnt + 1'b1;
                        frame_nx = FAIL_MSG;
                    end else begin
                        state_nx = LOCKOUT;
                        fail_nx  = '0;
                    end
                end else if (press[2]) begin
                    digit_nx  = '{default: '0};
                    cursor_nx = '0;
                end else if (press[1]) begin
                    cursor_nx = cursor == CW'(DIGITS - 1) ? '0 : cursor + 1'b1;
                end else if (press[0]) begin
                    for (int i = 0; i < DIGITS; i++)
                        if (cursor == CW'(i)) digit_nx[i] = digit[i] == 4'd9 ? 4'd0 : digit[i] + 1'b1;
                end
            end
            PASS, FAIL: begin
                if (press[3]) begin
                    state_nx  = ENTRY;
                    digit_nx  = '{default: '0};
                    cursor_nx = '0;
                end else if (scroll_cnt == SCW'(SCROLL_CYC - 1)) begin
                    frame_nx = {frame[DW-5:0], frame[DW-1:DW-4]};
                end else begin
                    scroll_nx = scroll_cnt + 1'b1;
                end
            end
            default: begin
                if (lock_cnt == LKW'(LOCKOUT_CYC - 1)) begin
                    state_nx  = ENTRY;
                    digit_nx  = '{default: '0};
                    cursor_nx = '0;
                end else begin
                    lock_nx = lock_cnt + 1'b1;
                end
            end
        endcase
    end

    always_comb begin
        disp = {NUM_DISP{BLANK}};
        if (state == LOCKOUT) disp = {NUM_DISP{DASH}};
        else if (state != ENTRY) disp = frame;
        else
            for (int i = 0; i < DIGITS; i++)
                disp[4*i +: 4] = (blink_off && cursor == CW'(i)) ? BLANK : digit[i];
    end

    assign unlocked   = state == PASS;
    assign locked_out = state == LOCKOUT;
    assign tries_left = TW'(MAX_TRIES) - fail_cnt;
endmodule

// File: tb/tb_combo_lock_ctrl.sv
// tb_combo_lock_ctrl: scoreboard bench for combo_lock_ctrl with shortened timers
module tb_combo_lock_ctrl;
    import combo_lock_pkg::*;
    localparam int DIG = 3, ND = 6, DEB = 4, SCR = 8, BLK = 16, MT = 3, LCK = 50, SW = 10;

    typedef struct {
        string       n;
        logic [27:0] v;
    } exp_t;

    logic          CLOCK_50 = 1'b0;
    logic          reset    = 1'b1;
    logic [SW-1:0] secret   = '0;
    logic [3:0]    key_n    = 4'hF;
    logic [4*ND-1:0] disp;
    logic          unlocked, locked_out;
    logic [1:0]    tries_left;
    logic [27:0]   obs;
    int            errors = 0, checks = 0, cyc = 0;
    exp_t          sb[$];
    exp_t          e;
    int            m_dig[DIG];
    int            m_cur, m_fail;
    state_t        m_state;
    logic [23:0]   m_frame;

    combo_lock_ctrl #(
        .DIGITS(DIG), .SECRET_W(SW), .NUM_DISP(ND), .DEBOUNCE_CYC(DEB),
        .SCROLL_CYC(SCR), .BLINK_CYC(BLK), .MAX_TRIES(MT), .LOCKOUT_CYC(LCK)
    ) dut (
        .CLOCK_50  (CLOCK_50),
        .reset     (reset),
        .secret    (secret),
        .key_n     (key_n),
        .disp      (disp),
        .unlocked  (unlocked),
        .locked_out(locked_out),
        .tries_left(tries_left)
    );

    always #10 CLOCK_50 = ~CLOCK_50;
    always @(posedge CLOCK_50) cyc <= reset ? 0 : cyc + 1;
    assign obs = {disp, unlocked, locked_out, tries_left};

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1);
    end

    function automatic logic [27:0] model_out();
        logic [23:0] d = '1;
        case (m_state)
            ENTRY:      for (int i = 0; i < DIG; i++)
                            d[4*i +: 4] = (((cyc / BLK) % 2) == 1 && m_cur == i) ? 4'd15 : 4'(m_dig[i]);
            PASS, FAIL: d = m_frame;
            default:    d = {ND{4'd14}};
        endcase
        return {d, m_state == PASS, m_state == LOCKOUT, 2'(MT - m_fail)};
    endfunction

    task automatic model_clear();
        for (int i = 0; i < DIG; i++) m_dig[i] = 0;
        m_cur = 0;
    endtask

    task automatic model_reset();
        model_clear();
        m_fail  = 0;
        m_state = ENTRY;
        m_frame = '1;
    endtask

    task automatic model_apply(input logic [3:0] k);
        int v;
        v = m_dig[0] + 10 * m_dig[1] + 100 * m_dig[2];
        case (m_state)
            ENTRY: begin
                if (k[3]) begin
                    if (v == int'(secret)) begin
                        m_state = PASS; m_fail = 0; m_frame = 24'hFFAB55;
                    end else if (m_fail + 1 < MT) begin
                        m_state = FAIL; m_fail++; m_frame = 24'hFFCB1D;
                    end else begin
                        m_state = LOCKOUT; m_fail = 0;
                    end
                end else if (k[2]) model_clear();
                else if (k[1]) m_cur = (m_cur + 1) % DIG;
                else if (k[0]) m_dig[m_cur] = (m_dig[m_cur] + 1) % 10;
            end
            PASS, FAIL: if (k[3]) begin m_state = ENTRY; model_clear(); end
            default: ;
        endcase
    endtask

    // Returns on the falling edge right after the edge that acts on the pulse (hold >= DEB+1).
    task automatic press(input logic [3:0] keys, input int hold);
        @(negedge CLOCK_50);
        key_n = ~keys;
        repeat (hold) @(posedge CLOCK_50);
        @(negedge CLOCK_50);
        key_n = 4'hF;
        if (hold > DEB) model_apply(keys);
    endtask

    task automatic enter_code(input int d2, input int d1, input int d0);
        repeat (d0) press(4'b0001, DEB + 1);
        press(4'b0010, DEB + 1);
        repeat (d1) press(4'b0001, DEB + 1);
        press(4'b0010, DEB + 1);
        repeat (d2) press(4'b0001, DEB + 1);
        press(4'b0010, DEB + 1);
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (3) @(posedge CLOCK_50);
        @(negedge CLOCK_50);
        reset = 1'b0;
        model_reset();
        sb.push_back('{"reset_state", {24'hFFF000, 1'b0, 1'b0, 2'd3}});
        e = sb.pop_front(); checks++;
        if (obs !== e.v) begin errors++; $display("FAIL %s: got %h expected %h", e.n, obs, e.v); end
    endtask

    task automatic test_debounce();
        press(4'b0001, DEB - 1);
        sb.push_back('{"short_press_ignored", model_out()});
        e = sb.pop_front(); checks++;
        if (obs !== e.v) begin errors++; $display("FAIL %s: got %h expected %h", e.n, obs, e.v); end
        press(4'b0001, 20);
        sb.push_back('{"held_key_one_pulse", model_out()});
        e = sb.pop_front(); checks++;
        if (obs !== e.v) begin errors++; $display("FAIL %s: got %h expected %h", e.n, obs, e.v); end
        press(4'b0001, DEB + 1);
        sb.push_back('{"repress_digit2", model_out()});
        e = sb.pop_front(); checks++;
        if (obs !== e.v) begin errors++; $display("FAIL %s: got %h expected %h", e.n, obs, e.v); end
        repeat (8) press(4'b0001, DEB + 1);
        sb.push_back('{"digit_wraps_to_0", model_out()});
        e = sb.pop_front(); checks++;
        if (obs !== e.v || m_dig[0] != 0) begin errors++; $display("FAIL %s: got %h expected %h", e.n, obs, e.v); end
    endtask

    task automatic test_clear_priority();
        press(4'b0001, DEB + 1);
        press(4'b0010, DEB + 1);
        press(4'b0001, DEB + 1);
        press(4'b0001, DEB + 1);
        sb.push_back('{"digits_before_clear", model_out()});
        e = sb.pop_front(); checks++;
        if (obs !== e.v) begin errors++; $display("FAIL %s: got %h expected %h", e.n, obs, e.v); end
        press(4'b0110, DEB + 1);
        sb.push_back('{"clear_beats_cursor", model_out()});
        e = sb.pop_front(); checks++;
        if (obs !== e.v || m_cur != 0) begin errors++; $display("FAIL %s: got %h expected %h", e.n, obs, e.v); end
        press(4'b0011, DEB + 1);
        sb.push_back('{"cursor_beats_inc", model_out()});
        e = sb.pop_front(); checks++;
        if (obs !== e.v) begin errors++; $display("FAIL %s: got %h expected %h", e.n, obs, e.v); end
        press(4'b0100, DEB + 1);
    endtask

    task automatic test_pass_scroll();
        secret = 10'd724;
        enter_code(7, 2, 4);
        sb.push_back('{"code_724_entered", model_out()});
        e = sb.pop_front(); checks++;
        if (obs !== e.v) begin errors++; $display("FAIL %s: got %h expected %h", e.n, obs, e.v); end
        press(4'b1000, DEB + 1);
        sb.push_back('{"pass_frame", {24'hFFAB55, 1'b1, 1'b0, 2'd3}});
        sb.push_back('{"pass_not_rotated_7", {24'hFFAB55, 1'b1, 1'b0, 2'd3}});
        sb.push_back('{"pass_rotated_8", {24'hFAB55F, 1'b1, 1'b0, 2'd3}});
        e = sb.pop_front(); checks++;
        if (obs !== e.v) begin errors++; $display("FAIL %s: got %h expected %h", e.n, obs, e.v); end
        repeat (SCR - 1) @(posedge CLOCK_50);
        @(negedge CLOCK_50);
        e = sb.pop_front(); checks++;
        if (obs !== e.v) begin errors++; $display("FAIL %s: got %h expected %h", e.n, obs, e.v); end
        @(posedge CLOCK_50);
        @(negedge CLOCK_50);
        e = sb.pop_front(); checks++;
        if (obs !== e.v) begin errors++; $display("FAIL %s: got %h expected %h", e.n, obs, e.v); end
        press(4'b0001, DEB + 1);
        sb.push_back('{"pass_ignores_inc", {24'hFAB55F, 1'b1, 1'b0, 2'd3}});
        e = sb.pop_front(); checks++;
        if (obs !== e.v) begin errors++; $display("FAIL %s: got %h expected %h", e.n, obs, e.v); end
        press(4'b1000, DEB + 1);
        sb.push_back('{"pass_return_entry", model_out()});
        e = sb.pop_front(); checks++;
        if (obs !== e.v) begin errors++; $display("FAIL %s: got %h expected %h", e.n, obs, e.v); end
    endtask

    task automatic test_lockout();
        for (int t = 0; t < MT - 1; t++) begin
            press(4'b1000, DEB + 1);
            sb.push_back('{"fail_frame_tries", model_out()});
            e = sb.pop_front(); checks++;
            if (obs !== e.v) begin errors++; $display("FAIL %s: got %h expected %h", e.n, obs, e.v); end
            press(4'b1000, DEB + 1);
            sb.push_back('{"fail_return_entry", model_out()});
            e = sb.pop_front(); checks++;
            if (obs !== e.v) begin errors++; $display("FAIL %s: got %h expected %h", e.n, obs, e.v); end
        end
        press(4'b1000, DEB + 1);
        sb.push_back('{"lockout_entered", {24'hEEEEEE, 1'b0, 1'b1, 2'd3}});
        sb.push_back('{"lockout_at_49", {24'hEEEEEE, 1'b0, 1'b1, 2'd3}});
        e = sb.pop_front(); checks++;
        if (obs !== e.v) begin errors++; $display("FAIL %s: got %h expected %h", e.n, obs, e.v); end
        repeat (LCK - 1) @(posedge CLOCK_50);
        @(negedge CLOCK_50);
        e = sb.pop_front(); checks++;
        if (obs !== e.v) begin errors++; $display("FAIL %s: got %h expected %h", e.n, obs, e.v); end
        @(posedge CLOCK_50);
        @(negedge CLOCK_50);
        m_state = ENTRY;
        model_clear();
        sb.push_back('{"lockout_exit_50", model_out()});
        e = sb.pop_front(); checks++;
        if (obs !== e.v || tries_left !== 2'd3) begin errors++; $display("FAIL %s: got %h expected %h", e.n, obs, e.v); end
    endtask

    task automatic test_reset_midop();
        repeat (MT) begin
            press(4'b1000, DEB + 1);
            if (m_state == FAIL) press(4'b1000, DEB + 1);
        end
        press(4'b0111, DEB + 1);
        sb.push_back('{"lockout_ignores_keys", {24'hEEEEEE, 1'b0, 1'b1, 2'd3}});
        e = sb.pop_front(); checks++;
        if (obs !== e.v) begin errors++; $display("FAIL %s: got %h expected %h", e.n, obs, e.v); end
        @(negedge CLOCK_50);
        reset = 1'b1;
        @(posedge CLOCK_50);
        @(negedge CLOCK_50);
        reset = 1'b0;
        model_reset();
        sb.push_back('{"reset_in_lockout", {24'hFFF000, 1'b0, 1'b0, 2'd3}});
        e = sb.pop_front(); checks++;
        if (obs !== e.v) begin errors++; $display("FAIL %s: got %h expected %h", e.n, obs, e.v); end
        enter_code(7, 2, 4);
        press(4'b1000, DEB + 1);
        repeat (SCR + 3) @(posedge CLOCK_50);
        @(negedge CLOCK_50);
        reset = 1'b1;
        @(posedge CLOCK_50);
        @(negedge CLOCK_50);
        reset = 1'b0;
        model_reset();
        sb.push_back('{"reset_in_pass", {24'hFFF000, 1'b0, 1'b0, 2'd3}});
        e = sb.pop_front(); checks++;
        if (obs !== e.v) begin errors++; $display("FAIL %s: got %h expected %h", e.n, obs, e.v); end
    endtask

    task automatic test_back_to_back();
        repeat (2) begin
            press(4'b1000, DEB + 1);
            press(4'b1000, DEB + 1);
        end
        sb.push_back('{"two_fails_tries1", model_out()});
        e = sb.pop_front(); checks++;
        if (obs !== e.v || tries_left !== 2'd1) begin errors++; $display("FAIL %s: got %h expected %h", e.n, obs, e.v); end
        enter_code(7, 2, 4);
        press(4'b1000, DEB + 1);
        sb.push_back('{"pass_restores_tries", {24'hFFAB55, 1'b1, 1'b0, 2'd3}});
        e = sb.pop_front(); checks++;
        if (obs !== e.v) begin errors++; $display("FAIL %s: got %h expected %h", e.n, obs, e.v); end
        press(4'b1000, DEB + 1);
        press(4'b1000, DEB + 1);
        sb.push_back('{"single_fail_tries2", {24'hFFCB1D, 1'b0, 1'b0, 2'd2}});
        e = sb.pop_front(); checks++;
        if (obs !== e.v) begin errors++; $display("FAIL %s: got %h expected %h", e.n, obs, e.v); end
    endtask

    initial begin
        test_reset();
        test_debounce();
        test_clear_priority();
        test_pass_scroll();
        test_lockout();
        test_reset_midop();
        test_back_to_back();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
